// File: rtl/rv32i_loader_pkg.sv
// Shared definitions for the serial program loader: FSM encoding, frame layout, length width.
// Pure declarations; no logic, no latency, no flow control.
package rv32i_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_CHECK  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } state_t;

    localparam int LEN_W          = 16;
    localparam int OFS_LEN_LO     = 0;
    localparam int OFS_LEN_HI     = 1;
    localparam int OFS_PAYLOAD    = 2;
    localparam int BYTES_PER_WORD = 4;

    function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte stream in and instruction-memory write port out of the program loader.
// Wires only; byte accepted when byte_valid and byte_ready are both high.
interface program_loader_if;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        im_we;
    logic [31:0] im_addr;
    logic [31:0] im_wdata;

    modport master (
        output byte_valid, byte_data,
        input  byte_ready, im_we, im_addr, im_wdata
    );

    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, im_we, im_addr, im_wdata
    );
endinterface

// File: rtl/program_loader_word_assembler.sv
// Packs little-endian payload bytes into 32-bit words, pulsing word_vld once per word.
// Latency: word_vld/word_dat register one cycle after the 4th byte; never stalls its source.
module word_assembler (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        byte_vld,
    input  logic [7:0]  byte_dat,
    output logic        last_lane,
    output logic        word_vld,
    output logic [31:0] word_dat
);

    logic [1:0]  lane;
    logic [23:0] shift;

    assign last_lane = (lane == 2'd3);

    // Bytes enter at the top so b0 ends up in the low lane once b3 arrives.
    always_ff @(posedge clk) begin
        if (!rst) begin
            lane     <= 2'd0;
            shift    <= 24'd0;
            word_vld <= 1'b0;
            word_dat <= 32'd0;
        end else begin
            word_vld <= 1'b0;
            if (clr) begin
                lane <= 2'd0;
            end else if (byte_vld) begin
                lane  <= lane + 2'd1;
                shift <= {byte_dat, shift[23:8]};
                if (last_lane) begin
                    word_vld <= 1'b1;
                    word_dat <= {byte_dat, shift};
                end
            end
        end
    end

endmodule

// File: rtl/program_loader.sv
// Receives a length-prefixed, XOR-checked program frame and writes it into instruction memory.
// Latency: one im_we pulse the cycle after each word's 4th byte; byte_ready never drops inside a frame.
module program_loader
    import rv32i_loader_pkg::*;
#(
    parameter int DEPTH = 100
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    program_loader_if.slave        bus,
    output logic                   core_rst_n,
    output logic                   done,
    output logic                   error
);

    localparam int          WCW     = $clog2(DEPTH + 1);
    localparam logic [31:0] DEPTH_U = 32'(DEPTH);

    state_t             state;
    state_t             state_nxt;
    logic [7:0]         len_lo;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   len_full;
    logic [7:0]         csum;
    logic [WCW-1:0]     word_cnt;
    logic               hs;
    logic               data_hs;
    logic               last_lane;
    logic               word_fire;
    logic               last_word;
    logic               new_load;

    assign hs        = bus.byte_valid & bus.byte_ready;
    assign data_hs   = hs && (state == ST_DATA);
    assign word_fire = data_hs && last_lane;
    assign len_full  = {bus.byte_data, len_lo};
    assign last_word = (32'(word_cnt) + 32'd1) == {16'd0, len_q};
    assign new_load  = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) state_nxt = ST_LEN_LO;
            end
            ST_LEN_LO: begin
                if (hs) state_nxt = ST_LEN_HI;
            end
            ST_LEN_HI: begin
                if (hs) begin
                    if (len_full == '0)                    state_nxt = ST_CHECK;
                    else if ({16'd0, len_full} > DEPTH_U)  state_nxt = ST_ERR;
                    else                                   state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (word_fire && last_word) state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                if (hs) state_nxt = (bus.byte_data == csum) ? ST_DONE : ST_ERR;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.byte_ready = 1'b0;
        done           = 1'b0;
        error          = 1'b0;
        core_rst_n     = 1'b0;
        case (state)
            ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CHECK: bus.byte_ready = 1'b1;
            ST_DONE: begin
                done       = 1'b1;
                core_rst_n = 1'b1;
            end
            ST_ERR:  error = 1'b1;
            default: ;
        endcase
    end

    // The checksum byte itself is not folded in; it is compared against csum instead.
    always_ff @(posedge clk) begin
        if (!rst) begin
            len_lo      <= 8'd0;
            len_q       <= '0;
            csum        <= 8'd0;
            word_cnt    <= '0;
            bus.im_addr <= 32'd0;
        end else if (new_load) begin
            len_lo   <= 8'd0;
            len_q    <= '0;
            csum     <= 8'd0;
            word_cnt <= '0;
        end else begin
            if (hs && (state != ST_CHECK)) csum <= csum_step(csum, bus.byte_data);
            if (hs && (state == ST_LEN_LO)) len_lo <= bus.byte_data;
            if (hs && (state == ST_LEN_HI)) len_q  <= len_full;
            if (word_fire) begin
                word_cnt    <= word_cnt + WCW'(1);
                bus.im_addr <= 32'(word_cnt) << 2;
            end
        end
    end

    word_assembler u_asm (
        .clk       (clk),
        .rst       (rst),
        .clr       (new_load),
        .byte_vld  (data_hs),
        .byte_dat  (bus.byte_data),
        .last_lane (last_lane),
        .word_vld  (bus.im_we),
        .word_dat  (bus.im_wdata)
    );

endmodule

// File: tb/tb_program_loader.sv
// Directed frames into program_loader; a negedge monitor scores every im_we against a queue.
module tb_program_loader;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic core_rst_n;
    logic done;
    logic error;

    program_loader_if bus ();

    program_loader #(.DEPTH(100)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .bus        (bus),
        .core_rst_n (core_rst_n),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [63:0] exp_q[$];
    logic [7:0]  tx_csum;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst && bus.im_we) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL im_we_unexpected: got addr %h data %h want no write", bus.im_addr, bus.im_wdata);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check32("im_addr", bus.im_addr, e[63:32]);
                check32("im_wdata", bus.im_wdata, e[31:0]);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int n = 0;
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        @(negedge clk);
        while (!bus.byte_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check1("byte_ready_timeout", bus.byte_ready, 1'b1);
        @(posedge clk);
        #1;
        bus.byte_valid = 1'b0;
        if (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_b(input logic [7:0] b, input bit gap);
        tx_csum = tx_csum ^ b;
        send_byte(b, gap);
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        for (int i = 0; i < 4; i++) send_b(w[8*i +: 8], gap);
    endtask

    task automatic pulse_start;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic sync;
        @(posedge clk);
        #1;
    endtask

    task automatic status(input string tag, input logic d, input logic e, input logic c, input logic r);
        @(negedge clk);
        check1({tag, "_done"}, done, d);
        check1({tag, "_error"}, error, e);
        check1({tag, "_core_rst_n"}, core_rst_n, c);
        check1({tag, "_byte_ready"}, bus.byte_ready, r);
        check32({tag, "_q_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        tx_csum        = 8'h00;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check1("rst_im_we", bus.im_we, 1'b0);
        check32("rst_im_addr", bus.im_addr, 32'h0);
        check32("rst_im_wdata", bus.im_wdata, 32'h0);
        check1("rst_core_rst_n", core_rst_n, 1'b0);
        check1("rst_done", done, 1'b0);
        check1("rst_error", error, 1'b0);
        check1("rst_byte_ready", bus.byte_ready, 1'b0);
        rst = 1'b1;
        sync();

        // Two-word program, good checksum (0xC3)
        pulse_start();
        @(negedge clk);
        check1("t1_ready_after_start", bus.byte_ready, 1'b1);
        sync();
        tx_csum = 8'h00;
        send_b(8'h02, 0);
        send_b(8'h00, 0);
        exp_q.push_back({32'h0, 32'h00500093});
        send_word(32'h00500093, 0);
        exp_q.push_back({32'h4, 32'h00100113});
        send_word(32'h00100113, 0);
        check32("t1_csum_model", {24'd0, tx_csum}, 32'hC3);
        send_byte(tx_csum, 0);
        status("t1", 1'b1, 1'b0, 1'b1, 1'b0);
        check32("t1_addr_hold", bus.im_addr, 32'h4);
        check32("t1_wdata_hold", bus.im_wdata, 32'h00100113);
        sync();

        // LEN = 101 exceeds capacity
        pulse_start();
        tx_csum = 8'h00;
        send_b(8'h65, 0);
        send_b(8'h00, 0);
        status("t2", 1'b0, 1'b1, 1'b0, 1'b0);
        check32("t2_addr_hold", bus.im_addr, 32'h4);
        sync();

        // One word, corrupted checksum
        pulse_start();
        tx_csum = 8'h00;
        send_b(8'h01, 0);
        send_b(8'h00, 0);
        exp_q.push_back({32'h0, 32'hFFFFFFFF});
        send_word(32'hFFFFFFFF, 0);
        send_byte(tx_csum ^ 8'h01, 0);
        status("t3", 1'b0, 1'b1, 1'b0, 1'b0);
        sync();

        // Reset after 5 payload bytes
        pulse_start();
        tx_csum = 8'h00;
        send_b(8'h02, 0);
        send_b(8'h00, 0);
        exp_q.push_back({32'h0, 32'h11223344});
        send_word(32'h11223344, 0);
        send_b(8'h55, 0);
        rst = 1'b0;
        sync();
        rst = 1'b1;
        status("t4", 1'b0, 1'b0, 1'b0, 1'b0);
        check32("t4_im_addr_rst", bus.im_addr, 32'h0);
        check32("t4_im_wdata_rst", bus.im_wdata, 32'h0);
        repeat (8) @(negedge clk);
        check1("t4_still_idle_ready", bus.byte_ready, 1'b0);
        sync();

        // byte_valid toggling, start pulsed mid-DATA
        pulse_start();
        tx_csum = 8'h00;
        send_b(8'h01, 1);
        send_b(8'h00, 1);
        exp_q.push_back({32'h0, 32'hDEADBEEF});
        send_b(8'hEF, 1);
        send_b(8'hBE, 1);
        pulse_start();
        @(negedge clk);
        check1("t5_ready_after_ignored_start", bus.byte_ready, 1'b1);
        check1("t5_core_rst_n_mid", core_rst_n, 1'b0);
        sync();
        send_b(8'hAD, 1);
        send_b(8'hDE, 1);
        check32("t5_csum_model", {24'd0, tx_csum}, 32'h23);
        send_byte(tx_csum, 1);
        status("t5", 1'b1, 1'b0, 1'b1, 1'b0);
        sync();

        // Empty program, then restart from DONE
        pulse_start();
        tx_csum = 8'h00;
        send_b(8'h00, 0);
        send_b(8'h00, 0);
        send_byte(8'h00, 0);
        status("t6", 1'b1, 1'b0, 1'b1, 1'b0);
        sync();
        pulse_start();
        @(negedge clk);
        check1("t6_restart_core_rst_n", core_rst_n, 1'b0);
        check1("t6_restart_done", done, 1'b0);
        check1("t6_restart_ready", bus.byte_ready, 1'b1);
        repeat (4) @(negedge clk);
        check32("t6_no_writes", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 100, meaning the instruction-memory capacity in 32-bit words.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port rst, input, 1, the reset: synchronous and active-low.
REQ-004 SHALL have port start, input, 1, a one-cycle request to begin a load.
REQ-005 SHALL have port byte_valid, input, 1, which qualifies byte_data.
REQ-006 SHALL have port byte_data, input, 8, the serial program byte.
REQ-007 SHALL have port byte_ready, output, 1; a byte is accepted when byte_valid and byte_ready are both 1.
REQ-008 SHALL have port im_we, output, 1, the instruction-memory write strobe.
REQ-009 SHALL have port im_addr, output, 32, the word-aligned byte address (word index x4).
REQ-010 SHALL have port im_wdata, output, 32, the assembled instruction word.
REQ-011 SHALL have port core_rst_n, output, 1, an active-low hold-in-reset for the RV32I core.
REQ-012 SHALL have port done, output, 1, meaning the load succeeded.
REQ-013 SHALL have port error, output, 1, meaning the load failed.

Function
REQ-014 SHALL accept this frame:
- byte 0: LEN[7:0]
- byte 1: LEN[15:8]
- then LEN*4 payload bytes, little-endian per word
- then one checksum byte, equal to the XOR of every preceding frame byte.
REQ-015 SHALL implement states IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE and ERR.
REQ-016 SHALL assert byte_ready only in LEN_LO, LEN_HI, DATA and CHECK.
REQ-017 SHALL make these transitions:
- IDLE -> LEN_LO on start.
- LEN_LO -> LEN_HI on a handshake.
- LEN_HI -> DATA on a handshake if 0 < LEN <= DEPTH.
- LEN_HI -> CHECK on a handshake if LEN = 0.
- LEN_HI -> ERR on a handshake if LEN > DEPTH.
- DATA -> CHECK on the handshake of the last byte of word LEN-1.
- CHECK -> DONE on a handshake if the checksum matches; otherwise CHECK -> ERR.
REQ-018 SHALL, in DONE or ERR, treat start as a new load: go to LEN_LO, clear done, error, the word counter and the checksum, and drive core_rst_n=0 in that same edge.
REQ-019 SHALL ignore start while in LEN_LO, LEN_HI, DATA or CHECK.
REQ-020 SHALL pulse im_we for exactly one cycle, on the cycle after the 4th byte handshake of word k.
- During that cycle: im_addr = 4*k, im_wdata = {b3,b2,b1,b0}.
- Outside write cycles: im_we=0, im_addr and im_wdata hold their last values.
REQ-021 SHALL keep byte_ready high during a write cycle, so back-to-back bytes incur no stall.
REQ-022 SHALL hold core_rst_n=0 in every state except DONE; in DONE, core_rst_n=1.
REQ-023 SHALL hold done=1 only in DONE and error=1 only in ERR.
REQ-024 SHALL use a word counter of ceil(log2(DEPTH+1)) bits that never exceeds LEN and never wraps.
- A 16-bit LEN is compared without truncation.
REQ-025 SHALL update the checksum on every accepted byte, including the length bytes, and not on the checksum byte itself.
REQ-026 SHALL ignore byte_valid when byte_ready=0; no state, counter or checksum changes.

Reset
REQ-027 SHALL, on a clk edge with rst=0, set:
- state = IDLE, im_we=0, im_addr=0, im_wdata=0
- core_rst_n=0, done=0, error=0, byte_ready=0
- word counter, byte counter and checksum = 0.
REQ-028 SHALL, when reset lands mid-load, abandon the frame with no further im_we pulse.
- Already-written memory words are left as they are.

Structure
REQ-029 SHALL place the state encoding, the frame byte offsets and the 16-bit LEN width in a shared package, rv32i_loader_pkg.
REQ-030 SHALL contain one sub-module, word_assembler: a byte-lane shift register plus a 2-bit byte counter that emits a word-valid pulse.

Verification
REQ-031 SHALL cover: start; frame LEN=2, words 0x00500093 and 0x00100113, correct checksum -> im_we at addr 0 then 4 with those words; done=1; core_rst_n=1.
REQ-032 SHALL cover: LEN=0x0065 (101 > DEPTH) -> ERR after byte 1; no im_we; error=1; core_rst_n=0.
REQ-033 SHALL cover: LEN=1, word 0xFFFFFFFF, checksum byte corrupted by ^0x01 -> im_we once at addr 0; error=1; done=0.
REQ-034 SHALL cover: rst=0 for one cycle after 5 payload bytes -> IDLE; no second im_we; byte_ready=0.
REQ-035 SHALL cover: byte_valid toggling 1-0-1 every cycle with LEN=1 -> the same word is written; and start pulsed mid-DATA -> ignored.
REQ-036 SHALL cover: LEN=0 with checksum 0x00 -> DONE with zero writes; start in DONE -> LEN_LO, core_rst_n=0 on the next cycle.
